i2c_controller: RTL

Byte-level I2C initiator that drives SCL/SDA as open-drain outputs and executes START, WRITE, READ and STOP commands issued over a valid/ready command port. It is the bus-driving counterpart of the design's I2C responder on uio[2] (SCL) and uio[3] (SDA), so the design can be driven from on-chip logic and loop-tested against the responder. The block is single-initiator: it honours responder clock stretching but does not perform multi-master arbitration.

---
 rtl/i2c_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_controller.sv
// Byte-level I2C initiator: executes START/WRITE/READ/STOP commands as open-drain SCL/SDA
// sequences of four quarters each, honouring responder clock stretching in Q1.
module i2c_controller #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] cmd_data,
   input  logic       cmd_ack,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_nack,
   output logic       busy,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_o,
   output logic       sda_o
);
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BIT, ST_STOP} state_t;

   localparam logic [1:0] CMD_START = 2'd0;
   localparam logic [1:0] CMD_WRITE = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_STOP  = 2'd3;
   localparam logic [9:0] Q_LAST    = 10'(CLK_DIV - 1);

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_s, sda_s;
   state_t     state_q, state_d;
   logic [1:0] quarter_q, quarter_d;
   logic [9:0] cnt_q, cnt_d;
   logic [1:0] settle_q, settle_d;
   logic [3:0] slot_q, slot_d;
   logic [1:0] op_q, op_d;
   logic [8:0] tx_q, tx_d;
   logic [8:0] rx_q, rx_d;
   logic       scl_q, scl_d, sda_q, sda_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_nack_q, rsp_nack_d;
   logic       busy_q, busy_d;
   logic       accept, q_end, done;

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign cmd_ready = (state_q == ST_IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign scl_o     = scl_q;
   assign sda_o     = sda_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_nack  = rsp_nack_q;
   assign busy      = busy_q;

   // Q1 first waits two cycles for released SCL to reach scl_s, then counts only while SCL is high
   always_comb begin
      if (quarter_q == 2'd1) q_end = (settle_q == 2'd2) && scl_s && (cnt_q == Q_LAST);
      else                   q_end = (cnt_q == Q_LAST);
      done = (state_q != ST_IDLE) && q_end && (quarter_q == 2'd3) &&
             ((state_q != ST_BIT) || (slot_q == 4'd8));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q  <= 2'b11;
         sda_sync_q  <= 2'b11;
         state_q     <= ST_IDLE;
         quarter_q   <= 2'd0;
         cnt_q       <= 10'd0;
         settle_q    <= 2'd0;
         slot_q      <= 4'd0;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_nack_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         scl_sync_q  <= {scl_sync_q[0], scl_i};
         sda_sync_q  <= {sda_sync_q[0], sda_i};
         state_q     <= state_d;
         quarter_q   <= quarter_d;
         cnt_q       <= cnt_d;
         settle_q    <= settle_d;
         slot_q      <= slot_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_nack_q  <= rsp_nack_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q <= op_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
   end

   always_comb begin
      state_d   = state_q;
      quarter_d = quarter_q;
      cnt_d     = cnt_q;
      settle_d  = settle_q;
      slot_d    = slot_q;
      if (state_q == ST_IDLE) begin
         if (accept) begin
            case (cmd)
               CMD_START: state_d = ST_START;
               CMD_STOP:  state_d = ST_STOP;
               default:   state_d = ST_BIT;
            endcase
            quarter_d = 2'd0;
            cnt_d     = 10'd0;
            settle_d  = 2'd0;
            slot_d    = 4'd0;
         end
      end else if (q_end) begin
         cnt_d     = 10'd0;
         settle_d  = 2'd0;
         quarter_d = quarter_q + 2'd1;
         if (quarter_q == 2'd3) begin
            if (done) state_d = ST_IDLE;
            else      slot_d  = slot_q + 4'd1;
         end
      end else if ((quarter_q == 2'd1) && ((settle_q != 2'd2) || !scl_s)) begin
         if (settle_q != 2'd2) settle_d = settle_q + 2'd1;
      end else begin
         cnt_d = cnt_q + 10'd1;
      end
   end

   always_comb begin
      scl_d       = scl_q;
      sda_d       = sda_q;
      op_d        = op_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rsp_valid_d = done;
      rsp_data_d  = rsp_data_q;
      rsp_nack_d  = rsp_nack_q;
      busy_d      = busy_q;
      if (accept) begin
         op_d = cmd;
         tx_d = (cmd == CMD_READ) ? {8'hFF, cmd_ack} : {cmd_data, 1'b1};
      end
      if ((state_q == ST_BIT) && q_end) begin
         if (quarter_q == 2'd2) rx_d = {rx_q[7:0], sda_s};
         if (quarter_q == 2'd3) tx_d = {tx_q[7:0], 1'b1};
      end
      if (done) begin
         case (state_q)
            ST_START: busy_d = 1'b1;
            ST_STOP:  busy_d = 1'b0;
            ST_BIT: begin
               if (op_q == CMD_WRITE) rsp_nack_d = rx_q[0];
               else                   rsp_data_d = rx_q[8:1];
            end
            default: ;
         endcase
      end
      // Line levels are registered on the edge that enters each quarter
      if ((state_d != ST_IDLE) && (accept || ((state_q != ST_IDLE) && q_end))) begin
         case (state_d)
            ST_START: begin
               case (quarter_d)
                  2'd0:    sda_d = 1'b1;
                  2'd1:    scl_d = 1'b1;
                  2'd2:    sda_d = 1'b0;
                  default: scl_d = 1'b0;
               endcase
            end
            ST_BIT: begin
               case (quarter_d)
                  2'd0: begin
                     scl_d = 1'b0;
                     sda_d = tx_d[8];
                  end
                  2'd1:    scl_d = 1'b1;
                  2'd3:    scl_d = 1'b0;
                  default: ;
               endcase
            end
            ST_STOP: begin
               case (quarter_d)
                  2'd0: begin
                     scl_d = 1'b0;
                     sda_d = 1'b0;
                  end
                  2'd1:    scl_d = 1'b1;
                  2'd2:    sda_d = 1'b1;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end
endmodule
